// File: rtl/cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor
//
// Run monitor for the single-cycle CPU. It watches the program counter,
// the instruction word and the register-file write port. It decides when a
// program has finished, either because the end address was reached or because
// the pc stopped moving (jump-to-self). A cycle-timeout guard covers programs
// that never finish. While running, it counts cycles and register writebacks.
// Each writeback is also captured into a first-word-fall-through trace FIFO
// that a testbench or debug host can drain.
//
// Optional feature (compile-time macro CPU_RUN_MONITOR_SYSCALL_HALT_EN):
//   When defined, a syscall instruction (opcode 0, funct 6'h0C) seen in RUN
//   also ends the run, with the same priority as the end_pc match.
//   When undefined, the instruction word is not inspected at all.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   start          single-cycle pulse; begins or restarts a run (ignored in RUN)
//   end_pc         address of the last instruction
//   pc             CPU program counter
//   instruction    instruction at pc
//   reg_we         register-file write enable
//   reg_waddr      register-file write address
//   reg_wdata      register-file write data
//   trace_rd       pop the trace FIFO head
//   trace_valid    FIFO not empty
//   trace_addr     head entry register number
//   trace_data     head entry data
//   trace_overflow sticky: a writeback was dropped because the FIFO was full
//   running        state is RUN
//   done           state is DONE
//   timeout        state is TIMEOUT
//   cycle_count    cycles spent in RUN
//   wb_count       accepted writebacks, dropped ones included
// -----------------------------------------------------------------------------
module cpu_run_monitor #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TRACE_DEPTH    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STALL_LIMIT    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] end_pc,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [31:0]           instruction,
    input  logic                  reg_we,
    input  logic [4:0]            reg_waddr,
    input  logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic                  trace_rd,
    output logic                  trace_valid,
    output logic [4:0]            trace_addr,
    output logic [DATA_WIDTH-1:0] trace_data,
    output logic                  trace_overflow,
    output logic                  running,
    output logic                  done,
    output logic                  timeout,
    output logic [31:0]           cycle_count,
    output logic [31:0]           wb_count
);

    localparam int PTR_W   = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int STALL_W = $clog2(STALL_LIMIT) + 1;
    localparam int ENTRY_W = DATA_WIDTH + 5;

    localparam logic [31:0]         TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [STALL_W-1:0]  STALL_LAST = STALL_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0]    FIFO_FULL  = CNT_W'(TRACE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 running_s;
    logic                 done_s;
    logic                 timeout_s;
    logic                 running_r;
    logic                 done_r;
    logic                 timeout_r;

    logic [31:0]          cycle_count_r;
    logic [31:0]          wb_count_r;
    logic                 overflow_r;

    logic [STALL_W-1:0]   stall_cnt_r;
    logic [ADDR_WIDTH-1:0] prev_pc_r;

    logic [ENTRY_W-1:0]   mem_r [TRACE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     fifo_cnt_r;
    logic [CNT_W-1:0]     fifo_cnt_nxt_s;
    logic                 trace_valid_r;
    logic [ENTRY_W-1:0]   head_s;

    logic                 run_s;
    logic                 start_s;
    logic                 pc_same_s;
    logic                 syscall_s;
    logic                 halt_s;
    logic                 tmo_s;
    logic                 wb_req_s;
    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 unused_instr_s;

    // A start pulse only counts outside RUN; a start during a run is ignored.
    assign run_s     = (state_r == ST_RUN);
    assign start_s   = start & ~run_s;
    assign pc_same_s = (pc == prev_pc_r);

`ifdef CPU_RUN_MONITOR_SYSCALL_HALT_EN
    assign syscall_s      = (instruction[31:26] == 6'd0) && (instruction[5:0] == 6'h0C);
    assign unused_instr_s = ^instruction[25:6];
`else
    assign syscall_s      = 1'b0;
    assign unused_instr_s = ^instruction;
`endif

    // The stall counter holds the number of earlier equal-pc cycles. When it
    // is already at STALL_LIMIT-1 and this cycle repeats the pc again, the pc
    // has been unchanged for STALL_LIMIT cycles.
    assign halt_s  = run_s & ((pc == end_pc) | syscall_s | (pc_same_s & (stall_cnt_r == STALL_LAST)));
    assign tmo_s   = run_s & ~halt_s & (cycle_count_r == TMO_LAST);

    assign wb_req_s     = run_s & reg_we & (reg_waddr != 5'd0);
    assign fifo_empty_s = (fifo_cnt_r == {CNT_W{1'b0}});
    assign fifo_full_s  = (fifo_cnt_r == FIFO_FULL);
    // A pop on an empty FIFO is meaningless. A push into a full FIFO is
    // accepted only when a pop frees a slot in the same cycle.
    assign pop_s        = trace_rd & ~fifo_empty_s;
    assign push_s       = wb_req_s & (~fifo_full_s | pop_s);
    assign drop_s       = wb_req_s & fifo_full_s & ~pop_s;

    // FSM state and registered state decodes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            running_r <= running_s;
            done_r    <= done_s;
            timeout_r <= timeout_s;
        end
    end

    // FSM next-state: halt has priority over timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (halt_s) begin
                    state_nxt_s = ST_DONE;
                end else if (tmo_s) begin
                    state_nxt_s = ST_TIMEOUT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: decode of the upcoming state, registered alongside it
    always_comb begin
        running_s = 1'b0;
        done_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_nxt_s)
            ST_RUN:     running_s = 1'b1;
            ST_DONE:    done_s    = 1'b1;
            ST_TIMEOUT: timeout_s = 1'b1;
            default: begin
                running_s = 1'b0;
                done_s    = 1'b0;
                timeout_s = 1'b0;
            end
        endcase
    end

    // Run counters and sticky overflow; frozen outside RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_r <= 32'd0;
            wb_count_r    <= 32'd0;
            overflow_r    <= 1'b0;
        end else if (start_s) begin
            cycle_count_r <= 32'd0;
            wb_count_r    <= 32'd0;
            overflow_r    <= 1'b0;
        end else if (run_s) begin
            cycle_count_r <= cycle_count_r + 32'd1;
            if (wb_req_s) begin
                wb_count_r <= wb_count_r + 32'd1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Stall detection: consecutive cycles where pc repeats the previous value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {STALL_W{1'b0}};
            prev_pc_r   <= {ADDR_WIDTH{1'b0}};
        end else if (start_s) begin
            stall_cnt_r <= {STALL_W{1'b0}};
            prev_pc_r   <= pc;
        end else if (run_s) begin
            stall_cnt_r <= pc_same_s ? (stall_cnt_r + STALL_W'(1)) : {STALL_W{1'b0}};
            prev_pc_r   <= pc;
        end
    end

    // FIFO occupancy after this edge
    always_comb begin
        fifo_cnt_nxt_s = fifo_cnt_r;
        if (start_s) begin
            fifo_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_nxt_s = fifo_cnt_r;
            endcase
        end
    end

    // FIFO pointers, occupancy and registered not-empty flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            fifo_cnt_r    <= {CNT_W{1'b0}};
            trace_valid_r <= 1'b0;
        end else begin
            fifo_cnt_r    <= fifo_cnt_nxt_s;
            trace_valid_r <= (fifo_cnt_nxt_s != {CNT_W{1'b0}});
            if (start_s) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage; contents are only observable through a valid head
    always_ff @(posedge clk) begin
        if (push_s && !start_s) begin
            mem_r[wr_ptr_r] <= {reg_waddr, reg_wdata};
        end
    end

    // Fall-through head, forced to zero while the FIFO is empty so that the
    // outputs read 0 after reset instead of stale storage.
    assign head_s         = mem_r[rd_ptr_r];
    assign trace_valid    = trace_valid_r;
    assign trace_addr     = trace_valid_r ? head_s[ENTRY_W-1:DATA_WIDTH] : 5'd0;
    assign trace_data     = trace_valid_r ? head_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
    assign trace_overflow = overflow_r;
    assign running        = running_r;
    assign done           = done_r;
    assign timeout        = timeout_r;
    assign cycle_count    = cycle_count_r;
    assign wb_count       = wb_count_r;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_monitor
//
// Directed bench for cpu_run_monitor (TRACE_DEPTH=4, TIMEOUT_CYCLES=16,
// STALL_LIMIT=4). A behavioural model (state name, counters, a queue for the
// trace FIFO) advances on every rising edge from the sampled inputs. A compare
// process checks every DUT output against it on each falling edge. Literal
// expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_cpu_run_monitor;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int STALL = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    localparam int M_TMO  = 3;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] end_pc;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        trace_rd;
    logic        trace_valid;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic        trace_overflow;
    logic        running;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] wb_count;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int          m_state;
    logic [31:0] m_cyc;
    logic [31:0] m_wb;
    logic        m_ovf;
    logic [31:0] m_prev;
    int          m_same;
    logic [36:0] mq[$];

    cpu_run_monitor #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TRACE_DEPTH   (DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .STALL_LIMIT   (STALL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .end_pc        (end_pc),
        .pc            (pc),
        .instruction   (instruction),
        .reg_we        (reg_we),
        .reg_waddr     (reg_waddr),
        .reg_wdata     (reg_wdata),
        .trace_rd      (trace_rd),
        .trace_valid   (trace_valid),
        .trace_addr    (trace_addr),
        .trace_data    (trace_data),
        .trace_overflow(trace_overflow),
        .running       (running),
        .done          (done),
        .timeout       (timeout),
        .cycle_count   (cycle_count),
        .wb_count      (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = M_IDLE;
        m_cyc   = 32'd0;
        m_wb    = 32'd0;
        m_ovf   = 1'b0;
        m_prev  = 32'd0;
        m_same  = 0;
        mq.delete();
    endtask

    // One rising edge of the spec's rules, applied to the sampled inputs
    task automatic m_step();
        bit   pop_ok;
        bit   eq;
        bit   halt;
        bit   sc;
        int   sz;
        sz     = mq.size();
        pop_ok = trace_rd && (sz != 0);
`ifdef CPU_RUN_MONITOR_SYSCALL_HALT_EN
        sc = (instruction[31:26] == 6'd0) && (instruction[5:0] == 6'h0C);
`else
        sc = 1'b0;
`endif
        if (start && m_state != M_RUN) begin
            m_state = M_RUN;
            m_cyc   = 32'd0;
            m_wb    = 32'd0;
            m_ovf   = 1'b0;
            m_prev  = pc;
            m_same  = 0;
            mq.delete();
        end else begin
            if (pop_ok) void'(mq.pop_front());
            if (m_state == M_RUN) begin
                if (reg_we && reg_waddr != 5'd0) begin
                    m_wb = m_wb + 32'd1;
                    if (sz == DEPTH && !pop_ok) m_ovf = 1'b1;
                    else mq.push_back({reg_waddr, reg_wdata});
                end
                eq     = (pc == m_prev);
                m_same = eq ? m_same + 1 : 0;
                halt   = (pc == end_pc) || (m_same >= STALL) || sc;
                if (halt) m_state = M_DONE;
                else if (m_cyc == 32'(TMO - 1)) m_state = M_TMO;
                m_cyc  = m_cyc + 32'd1;
                m_prev = pc;
            end
        end
    endtask

    // Advance one clock: model follows the edge, then inputs may change at +1
    task automatic cyc();
        @(posedge clk);
        if (reset) m_reset();
        else m_step();
        #1;
    endtask

    // Compare every DUT output against the model away from the active edge
    always @(negedge clk) begin
        chk("running", running, m_state == M_RUN);
        chk("done", done, m_state == M_DONE);
        chk("timeout", timeout, m_state == M_TMO);
        chk("cycle_count", cycle_count, m_cyc);
        chk("wb_count", wb_count, m_wb);
        chk("trace_overflow", trace_overflow, m_ovf);
        chk("trace_valid", trace_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("trace_addr", trace_addr, mq[0][36:32]);
            chk("trace_data", trace_data, mq[0][31:0]);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_running"}, running, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_timeout"}, timeout, 1'b0);
        chk({tag, "_cycles"}, cycle_count, 32'd0);
        chk({tag, "_wb"}, wb_count, 32'd0);
        chk({tag, "_valid"}, trace_valid, 1'b0);
        chk({tag, "_addr"}, trace_addr, 5'd0);
        chk({tag, "_data"}, trace_data, 32'd0);
        chk({tag, "_ovf"}, trace_overflow, 1'b0);
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        reg_we    = we;
        reg_waddr = a;
        reg_wdata = d;
    endtask

    task automatic pop_check(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_valid"}, trace_valid, 1'b1);
        chk({tag, "_addr"}, trace_addr, a);
        chk({tag, "_data"}, trace_data, d);
        trace_rd = 1'b1;
        cyc();
        trace_rd = 1'b0;
    endtask

    initial begin
        m_reset();
        reset = 1'b1; start = 1'b0; end_pc = 32'd0; pc = 32'd0;
        instruction = 32'd0; trace_rd = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        #12;
        reset = 1'b0;
        chk_zero("por");

        // ---- async reset in the middle of a run with 3 FIFO entries ----
        end_pc = 32'hFFFF_FFF0; pc = 32'h100; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h104 + 32'(4 * i);
            wb(1'b1, 5'(i + 1), 32'h11 * 32'(i + 1));
            cyc();
        end
        wb(1'b0, 5'd0, 32'd0);
        chk("pre_reset_wb", wb_count, 32'd3);
        chk("pre_reset_run", running, 1'b1);
        #2 reset = 1'b1;
        #1 chk_zero("async");
        m_reset();
        #2 reset = 1'b0;
        cyc();
        chk("idle_after_reset", running, 1'b0);

        // ---- end_pc match with three writebacks ----
        end_pc = 32'h8; pc = 32'h0; start = 1'b1;
        cyc();
        start = 1'b0;
        pc = 32'h0; wb(1'b1, 5'd8,  32'd5);  cyc();
        pc = 32'h4; wb(1'b1, 5'd9,  32'd7);  cyc();
        pc = 32'h8; wb(1'b1, 5'd10, 32'd12); cyc();
        wb(1'b0, 5'd0, 32'd0);
        chk("endpc_done", done, 1'b1);
        chk("endpc_cycles", cycle_count, 32'd3);
        chk("endpc_wb", wb_count, 32'd3);
        pop_check("pop0", 5'd8, 32'd5);
        pop_check("pop1", 5'd9, 32'd7);
        pop_check("pop2", 5'd10, 32'd12);
        chk("endpc_drained", trace_valid, 1'b0);
        chk("endpc_frozen", cycle_count, 32'd3);

        // ---- stall halt: pc held at 0x0C ----
        end_pc = 32'hFFFF_F000; pc = 32'h0; start = 1'b1;
        cyc();
        start = 1'b0;
        pc = 32'h4; cyc();
        pc = 32'hC;
        repeat (4) cyc();
        chk("stall_not_yet", running, 1'b1);
        cyc();
        chk("stall_done", done, 1'b1);
        chk("stall_cycles", cycle_count, 32'd6);
        chk("stall_no_tmo", timeout, 1'b0);

        // ---- timeout after 16 RUN cycles, then restart ----
        pc = 32'h40; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i < 16; i++) begin
            pc = 32'h40 + 32'(4 * i);
            cyc();
        end
        chk("tmo_not_yet", running, 1'b1);
        chk("tmo_cyc15", cycle_count, 32'd15);
        pc = 32'h80; cyc();
        chk("tmo_flag", timeout, 1'b1);
        chk("tmo_cycles", cycle_count, 32'd16);
        chk("tmo_not_done", done, 1'b0);
        pc = 32'h84; cyc();
        chk("tmo_frozen", cycle_count, 32'd16);
        pc = 32'h200; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_run", running, 1'b1);
        chk("restart_cycles", cycle_count, 32'd0);
        chk("restart_wb", wb_count, 32'd0);

        // ---- overflow: 6 writebacks into a 4-deep FIFO ----
        for (int i = 1; i <= 6; i++) begin
            pc = 32'h200 + 32'(4 * i);
            wb(1'b1, 5'(i), 32'h100 + 32'(i));
            cyc();
        end
        chk("ovf_flag", trace_overflow, 1'b1);
        chk("ovf_wb", wb_count, 32'd6);
        chk("ovf_head", trace_addr, 5'd1);
        pc = 32'h21C; wb(1'b1, 5'd0, 32'hDEAD); cyc();
        chk("zero_reg_wb", wb_count, 32'd6);
        pc = 32'h220; wb(1'b1, 5'd7, 32'h107); trace_rd = 1'b1; cyc();
        trace_rd = 1'b0;
        chk("full_pushpop_head", trace_addr, 5'd2);
        chk("full_pushpop_wb", wb_count, 32'd7);
        pc = 32'h224; end_pc = 32'h224; wb(1'b1, 5'd9, 32'h109); cyc();
        wb(1'b0, 5'd0, 32'd0);
        chk("ovf_done", done, 1'b1);
        chk("ovf_wb_final", wb_count, 32'd8);
        chk("ovf_cycles", cycle_count, 32'd9);
        pop_check("opop0", 5'd2, 32'h102);
        pop_check("opop1", 5'd3, 32'h103);
        pop_check("opop2", 5'd4, 32'h104);
        pop_check("opop3", 5'd7, 32'h107);
        chk("ovf_drained", trace_valid, 1'b0);

        // ---- syscall instruction, empty push+pop, start ignored in RUN ----
        end_pc = 32'h18; pc = 32'h0; start = 1'b1;
        cyc();
        start = 1'b0;
        pc = 32'h4; wb(1'b1, 5'd5, 32'h55); trace_rd = 1'b1; cyc();
        trace_rd = 1'b0; wb(1'b0, 5'd0, 32'd0);
        chk("empty_pushpop_valid", trace_valid, 1'b1);
        chk("empty_pushpop_addr", trace_addr, 5'd5);
        pc = 32'h8; start = 1'b1; cyc();
        start = 1'b0;
        chk("start_in_run_cycles", cycle_count, 32'd2);
        pc = 32'hC; cyc();
        pc = 32'h10; instruction = 32'h0000_000C; cyc();
        instruction = 32'd0;
`ifdef CPU_RUN_MONITOR_SYSCALL_HALT_EN
        chk("syscall_done", done, 1'b1);
        chk("syscall_cycles", cycle_count, 32'd4);
`else
        chk("syscall_ignored", running, 1'b1);
`endif
        pc = 32'h14; cyc();
        pc = 32'h18; cyc();
        chk("syscall_run_done", done, 1'b1);
`ifdef CPU_RUN_MONITOR_SYSCALL_HALT_EN
        chk("syscall_final_cycles", cycle_count, 32'd4);
`else
        chk("syscall_final_cycles", cycle_count, 32'd6);
`endif

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
